keypad_scanner: RTL and testbench

Drives a passive 4x3 key matrix and produces the 10-bit one-hot `keypad` vector consumed by the microwave controller (bit n = digit n). It scans rows one at a time and assembles a full-sweep image. It rejects multi-key and non-digit presses, debounces across sweeps, and holds a clean level while a key is held. It is the producing end of the controller's keypad interface.

---
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 tb/tb_keypad_scanner.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a passive 4x3 key matrix one row at a time.
// It builds a 12-bit image of each full sweep and classifies it as no key,
// one digit, an ignored key (* or #), or several keys. The result is
// debounced across whole sweeps and drives a clean one-hot digit level.
module keypad_scanner #(
    parameter int SCAN_CYCLES = 1,
    parameter int DEBOUNCE    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    output logic [3:0] row_n,
    input  logic [2:0] col_n,
    output logic [9:0] keypad,
    output logic       key_event,
    output logic       multi_key
);
    localparam int SLOT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE);

    logic [SLOT_W-1:0] slot_q,       slot_d;
    logic [1:0]        row_idx_q,    row_idx_d;
    logic [3:0]        row_n_q,      row_n_d;
    logic [11:0]       image_q,      image_d;
    logic [9:0]        prev_cand_q,  prev_cand_d;
    logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic              pend_q,       pend_d;
    logic [9:0]        pend_val_q,   pend_val_d;
    logic [9:0]        keypad_q,     keypad_d;
    logic              key_event_q,  key_event_d;
    logic              multi_key_q,  multi_key_d;

    logic              sample;
    logic              sweep_end;
    logic [11:0]       full_image;
    logic [3:0]        n_closed;
    logic [9:0]        single;
    logic [9:0]        cand;
    logic              cand_multi;
    logic [CNT_W-1:0]  stable_next;

    // Columns are read on the last slot of each row; row 3 closes the sweep.
    assign sample     = (slot_q == SLOT_LAST);
    assign sweep_end  = sample && (row_idx_q == 2'd3);
    // Row 3 is taken live so the sweep result is ready on its sampling edge.
    assign full_image = {~col_n, image_q[8:0]};

    // Classify the completed sweep: count closed switches and map to a digit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        n_closed = '0;
        single   = '0;
        for (int i = 0; i < 12; i++) begin
            n_closed = n_closed + 4'(full_image[i]);
        end
        // Image bits 0..8 are digits 1..9, bit 10 is digit 0; * and # map nowhere.
        for (int i = 0; i < 9; i++) begin
            single[i+1] = full_image[i];
        end
        single[0]  = full_image[10];
        cand       = (n_closed == 4'd1) ? single : '0;
        cand_multi = (n_closed > 4'd1);
    end

    // Row scan: advance slot and row, capture the sensed columns into the image.
    always_comb begin
        slot_d    = slot_q + 1'b1;
        row_idx_d = row_idx_q;
        image_d   = image_q;
        if (sample) begin
            slot_d    = '0;
            row_idx_d = row_idx_q + 2'd1;
            image_d[int'(row_idx_q) * 3 +: 3] = ~col_n;
        end
        row_n_d = ~(4'b0001 << row_idx_d);
    end

    // Debounce across sweeps; a settled change is applied one edge after the sweep ends.
    always_comb begin
        prev_cand_d  = prev_cand_q;
        stable_cnt_d = stable_cnt_q;
        multi_key_d  = multi_key_q;
        pend_d       = pend_q;
        pend_val_d   = pend_val_q;
        keypad_d     = keypad_q;
        key_event_d  = 1'b0;

        if (cand == prev_cand_q) begin
            stable_next = (stable_cnt_q >= CNT_MAX) ? CNT_MAX : stable_cnt_q + 1'b1;
        end else begin
            stable_next = CNT_W'(1);
        end

        // A pending update can never coincide with a sweep end (sweeps are >= 4 cycles).
        if (pend_q) begin
            keypad_d    = pend_val_q;
            key_event_d = |pend_val_q;
            pend_d      = 1'b0;
        end

        if (sweep_end) begin
            multi_key_d  = cand_multi;
            prev_cand_d  = cand;
            stable_cnt_d = stable_next;
            if ((stable_next == CNT_MAX) && (cand != keypad_q)) begin
                pend_d     = 1'b1;
                pend_val_d = cand;
            end
        end
    end

    // State registers; the sweep image is small and is cleared on reset as well.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot_q       <= '0;
            row_idx_q    <= 2'd0;
            row_n_q      <= 4'b1110;
            image_q      <= '0;
            prev_cand_q  <= '0;
            stable_cnt_q <= '0;
            pend_q       <= 1'b0;
            pend_val_q   <= '0;
            keypad_q     <= '0;
            key_event_q  <= 1'b0;
            multi_key_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            slot_q       <= slot_d;
            row_idx_q    <= row_idx_d;
            row_n_q      <= row_n_d;
            image_q      <= image_d;
            prev_cand_q  <= prev_cand_d;
            stable_cnt_q <= stable_cnt_d;
            pend_q       <= pend_d;
            pend_val_q   <= pend_val_d;
            keypad_q     <= keypad_d;
            key_event_q  <= key_event_d;
            multi_key_q  <= multi_key_d;
        end
    end

    assign row_n     = row_n_q;
    assign keypad    = keypad_q;
    assign key_event = key_event_q;
    assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: two scanners (default timing, and SCAN_CYCLES=3/DEBOUNCE=4)
// driven by a behavioural key-matrix model and compared against a sweep-level
// reference of the keypad rules.
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] pressed_a = '0;
    logic [11:0] pressed_b = '0;

    logic [3:0]  row_n_a, row_n_b;
    logic [2:0]  col_n_a, col_n_b;
    logic [9:0]  keypad_a, keypad_b;
    logic        key_event_a, key_event_b;
    logic        multi_key_a, multi_key_b;
    logic [15:0] got_a, got_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [9:0] kp;
        logic       ev;
        logic       mk;
        logic [9:0] prev;
        int         cnt;
        logic       pend;
        logic [9:0] pend_val;
    } model_t;

    model_t ma, mb;

    always #5 clock = ~clock;

    keypad_scanner #(.SCAN_CYCLES(1), .DEBOUNCE(2)) dut_a (
        .clock(clock), .resetn(resetn), .row_n(row_n_a), .col_n(col_n_a),
        .keypad(keypad_a), .key_event(key_event_a), .multi_key(multi_key_a)
    );

    keypad_scanner #(.SCAN_CYCLES(3), .DEBOUNCE(4)) dut_b (
        .clock(clock), .resetn(resetn), .row_n(row_n_b), .col_n(col_n_b),
        .keypad(keypad_b), .key_event(key_event_b), .multi_key(multi_key_b)
    );

    // Passive matrix: the driven row connects its closed switches to the columns.
    always_comb begin
        col_n_a = 3'b111;
        for (int r = 0; r < 4; r++) if (!row_n_a[r]) col_n_a = ~pressed_a[r*3 +: 3];
    end
    always_comb begin
        col_n_b = 3'b111;
        for (int r = 0; r < 4; r++) if (!row_n_b[r]) col_n_b = ~pressed_b[r*3 +: 3];
    end

    assign got_a = {row_n_a, keypad_a, key_event_a, multi_key_a};
    assign got_b = {row_n_b, keypad_b, key_event_b, multi_key_b};

    // Matrix position (row*3+col) to digit; -1 for * and #.
    function automatic int digit_of(input int pos);
        case (pos)
            0: return 1;  1: return 2;  2: return 3;
            3: return 4;  4: return 5;  5: return 6;
            6: return 7;  7: return 8;  8: return 9;
            10: return 0;
            default: return -1;
        endcase
    endfunction

    function automatic model_t model_clear();
        model_t m;
        m.cyc = 0; m.kp = '0; m.ev = 1'b0; m.mk = 1'b0;
        m.prev = '0; m.cnt = 0; m.pend = 1'b0; m.pend_val = '0;
        return m;
    endfunction

    // One rising edge of the reference: the key set held over a whole sweep
    // is judged when the sweep completes; a settled change shows one edge later.
    function automatic model_t model_step(input model_t m, input int sc, input int deb,
                                          input logic [11:0] keys);
        logic [9:0] cand;
        int n;
        m.ev = 1'b0;
        if (m.pend) begin
            m.kp   = m.pend_val;
            m.ev   = (m.pend_val != 0);
            m.pend = 1'b0;
        end
        m.cyc = m.cyc + 1;
        if (m.cyc % (4 * sc) == 0) begin
            n = $countones(keys);
            cand = '0;
            if (n == 1) begin
                for (int i = 0; i < 12; i++)
                    if (keys[i] && digit_of(i) >= 0) cand = 10'b1 << digit_of(i);
            end
            m.mk = (n > 1);
            if (cand == m.prev) m.cnt = (m.cnt + 1 > deb) ? deb : m.cnt + 1;
            else begin
                m.prev = cand;
                m.cnt  = 1;
            end
            if (m.cnt == deb && cand != m.kp) begin
                m.pend     = 1'b1;
                m.pend_val = cand;
            end
        end
        return m;
    endfunction

    function automatic logic [15:0] exp_vec(input model_t m, input int sc);
        logic [3:0] r;
        r = ~(4'b0001 << ((m.cyc / sc) % 4));
        return {r, m.kp, m.ev, m.mk};
    endfunction

    task automatic tick();
        @(posedge clock);
        ma = model_step(ma, 1, 2, pressed_a);
        mb = model_step(mb, 3, 4, pressed_b);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn    = 1'b0;
        pressed_a = '0;
        pressed_b = '0;
        @(negedge clock);
        resetn = 1'b1;
        ma = model_clear();
        mb = model_clear();
    endtask

    task automatic test_reset();
        logic [3:0] rows [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        apply_reset();
        pressed_a = 12'h010;                     // digit 5
        repeat (12) tick();
        total++;
        if (keypad_a !== 10'h020) begin
            bad++; $display("FAIL reset_pre_kp got=%h exp=%h", keypad_a, 10'h020);
        end
        repeat (2) tick();                       // now mid-sweep, row 2
        #2 resetn = 1'b0;
        #1;
        total++;
        if (got_a !== {4'b1110, 10'h000, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_async_a got=%h exp=%h", got_a, {4'b1110, 10'h000, 2'b00});
        end
        total++;
        if (got_b !== {4'b1110, 10'h000, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_async_b got=%h exp=%h", got_b, {4'b1110, 10'h000, 2'b00});
        end
        pressed_a = '0;
        @(negedge clock);
        resetn = 1'b1;
        ma = model_clear();
        mb = model_clear();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++;
            if (row_n_a !== rows[i]) begin
                bad++; $display("FAIL reset_rows edge=%0d got=%b exp=%b", i, row_n_a, rows[i]);
            end
        end
    endtask

    task automatic test_single_press();
        int rise_cyc = -1;
        int fall_cyc = -1;
        int events = 0;
        apply_reset();
        pressed_a = 12'h004;                     // digit 3 at r0,c2
        for (int i = 0; i < 36; i++) begin
            if (i == 20) pressed_a = '0;
            tick();
            total++;
            if (got_a !== exp_vec(ma, 1)) begin
                bad++; $display("FAIL single cyc=%0d got=%h exp=%h", ma.cyc, got_a, exp_vec(ma, 1));
            end
            if (key_event_a) events++;
            if (rise_cyc < 0 && keypad_a == 10'h008) rise_cyc = ma.cyc;
            if (i >= 20 && fall_cyc < 0 && keypad_a == 10'h000) fall_cyc = ma.cyc;
        end
        total++;
        if (rise_cyc != 9) begin
            bad++; $display("FAIL single_latency got=%0d exp=%0d", rise_cyc, 9);
        end
        total++;
        if (fall_cyc != 29) begin
            bad++; $display("FAIL single_release got=%0d exp=%0d", fall_cyc, 29);
        end
        total++;
        if (events != 1) begin
            bad++; $display("FAIL single_events got=%0d exp=%0d", events, 1);
        end
    endtask

    task automatic test_sequence();
        logic [11:0] keys [6]   = '{12'h001, 12'h000, 12'h004, 12'h000, 12'h400, 12'h000};
        int          sweeps [6] = '{6, 3, 6, 3, 6, 3};
        logic [9:0]  want [3]   = '{10'h002, 10'h008, 10'h001};
        logic [9:0]  seen [$];
        apply_reset();
        for (int s = 0; s < 6; s++) begin
            pressed_a = keys[s];
            repeat (4 * sweeps[s]) begin
                tick();
                total++;
                if (got_a !== exp_vec(ma, 1)) begin
                    bad++; $display("FAIL sequence cyc=%0d got=%h exp=%h", ma.cyc, got_a, exp_vec(ma, 1));
                end
                if (key_event_a) seen.push_back(keypad_a);
            end
        end
        total++;
        if (seen.size() != 3) begin
            bad++; $display("FAIL sequence_events got=%0d exp=%0d", seen.size(), 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (seen[i] !== want[i]) begin
                    bad++; $display("FAIL sequence_order idx=%0d got=%h exp=%h", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_two_keys();
        apply_reset();
        pressed_a = 12'h011;                     // digits 5 and 1 together
        for (int i = 0; i < 28; i++) begin
            if (i == 16) pressed_a = 12'h010;    // release 1
            tick();
            total++;
            if (got_a !== exp_vec(ma, 1)) begin
                bad++; $display("FAIL two_keys cyc=%0d got=%h exp=%h", ma.cyc, got_a, exp_vec(ma, 1));
            end
            if (ma.cyc == 4) begin
                total++;
                if (multi_key_a !== 1'b1) begin
                    bad++; $display("FAIL two_keys_multi got=%b exp=%b", multi_key_a, 1'b1);
                end
            end
        end
        total++;
        if ({keypad_a, multi_key_a} !== {10'h020, 1'b0}) begin
            bad++; $display("FAIL two_keys_after got=%h/%b exp=%h/%b", keypad_a, multi_key_a, 10'h020, 1'b0);
        end
    endtask

    task automatic test_bounce();
        int events = 0;
        apply_reset();
        for (int s = 0; s < 13; s++) begin
            pressed_a = (s >= 10 || s % 2 == 0) ? 12'h080 : 12'h000;   // digit 8
            repeat (4) begin
                tick();
                total++;
                if (got_a !== exp_vec(ma, 1)) begin
                    bad++; $display("FAIL bounce cyc=%0d got=%h exp=%h", ma.cyc, got_a, exp_vec(ma, 1));
                end
                if (s < 10 && (key_event_a || keypad_a != 0)) events++;
            end
        end
        total++;
        if (events != 0) begin
            bad++; $display("FAIL bounce_quiet got=%0d exp=%0d", events, 0);
        end
        total++;
        if (keypad_a !== 10'h100) begin
            bad++; $display("FAIL bounce_settle got=%h exp=%h", keypad_a, 10'h100);
        end
    endtask

    task automatic test_ignored();
        logic [11:0] keys [3] = '{12'h200, 12'h800, 12'h600};   // *, #, * with 0
        logic [1:0]  want [3] = '{2'b00, 2'b00, 2'b01};         // {keypad!=0, multi}
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            pressed_a = keys[k];
            repeat (16) begin
                tick();
                total++;
                if (got_a !== exp_vec(ma, 1)) begin
                    bad++; $display("FAIL ignored cyc=%0d got=%h exp=%h", ma.cyc, got_a, exp_vec(ma, 1));
                end
            end
            total++;
            if ({keypad_a != 0, multi_key_a} !== want[k]) begin
                bad++; $display("FAIL ignored_final case=%0d got=%b exp=%b", k, {keypad_a != 0, multi_key_a}, want[k]);
            end
        end
    endtask

    task automatic test_slow();
        int rise_cyc = -1;
        apply_reset();
        pressed_b = 12'h004;                     // digit 3 on the slow scanner
        for (int i = 0; i < 120; i++) begin
            if (i == 72) pressed_b = '0;
            tick();
            total++;
            if (got_b !== exp_vec(mb, 3)) begin
                bad++; $display("FAIL slow cyc=%0d got=%h exp=%h", mb.cyc, got_b, exp_vec(mb, 3));
            end
            if (rise_cyc < 0 && keypad_b == 10'h008) rise_cyc = mb.cyc;
        end
        total++;
        if (rise_cyc != 49) begin
            bad++; $display("FAIL slow_latency got=%0d exp=%0d", rise_cyc, 49);
        end
    endtask

    // Random key sets held for whole multiples of both sweep lengths.
    task automatic test_random();
        logic [11:0] ka, kb;
        apply_reset();
        for (int seg = 0; seg < 40; seg++) begin
            for (int d = 0; d < 2; d++) begin
                logic [11:0] k;
                int kind;
                kind = $urandom_range(0, 3);
                k = '0;
                if (kind == 1 || kind == 2) k[$urandom_range(0, 11)] = 1'b1;
                if (kind == 3) begin
                    k[$urandom_range(0, 5)]  = 1'b1;
                    k[$urandom_range(6, 11)] = 1'b1;
                end
                if (d == 0) ka = k; else kb = k;
            end
            pressed_a = ka;
            pressed_b = kb;
            repeat (12 * $urandom_range(1, 3)) begin
                tick();
                total++;
                if (got_a !== exp_vec(ma, 1)) begin
                    bad++; $display("FAIL random_a cyc=%0d got=%h exp=%h", ma.cyc, got_a, exp_vec(ma, 1));
                end
                total++;
                if (got_b !== exp_vec(mb, 3)) begin
                    bad++; $display("FAIL random_b cyc=%0d got=%h exp=%h", mb.cyc, got_b, exp_vec(mb, 3));
                end
                total++;
                if ($countones(keypad_a) > 1 || $countones(keypad_b) > 1) begin
                    bad++; $display("FAIL random_onehot got=%h/%h exp=onehot", keypad_a, keypad_b);
                end
            end
        end
    endtask

    initial begin
        ma = model_clear();
        mb = model_clear();
        test_reset();
        test_single_press();
        test_sequence();
        test_two_keys();
        test_bounce();
        test_ignored();
        test_slow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
